// File: rtl/fft_pkg.sv
// Shared constants and the per-frame result record for the FFT peak detector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fft_pkg;

  localparam int N_POINTS = 16;
  localparam int DATA_W   = 16;
  localparam int BIN_W    = $clog2(N_POINTS);
  localparam int MAG_W    = 2 * DATA_W;
  localparam int ENERGY_W = MAG_W + BIN_W;

  // One record per completed frame.
  typedef struct packed {
    logic [BIN_W-1:0]    peak_bin;
    logic [MAG_W-1:0]    peak_mag;
    logic [ENERGY_W-1:0] energy;
  } result_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Registered magnitude-squared of one complex bin, with valid and bin index carried alongside.
// Latency: 1 cycle from in_vld to out_vld.
// Backpressure: none; the caller only asserts in_vld for accepted bins.
module fft_mag_sq
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_vld,
  input  logic [BIN_W-1:0]         in_bin,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     out_vld,
  output logic [BIN_W-1:0]         out_bin,
  output logic [MAG_W-1:0]         out_mag
);

  logic signed [MAG_W-1:0] re_sq;
  logic signed [MAG_W-1:0] im_sq;
  logic [MAG_W-1:0]        mag_sum;

  // Each signed square is at most 2^30, so the unsigned sum (max 2^31) fits without saturation.
  always_comb begin
    re_sq   = MAG_W'(in_real) * MAG_W'(in_real);
    im_sq   = MAG_W'(in_imag) * MAG_W'(in_imag);
    mag_sum = $unsigned(re_sq) + $unsigned(im_sq);
  end

  // Pipeline register: magnitude, valid and bin index move together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld <= 1'b0;
      out_bin <= '0;
      out_mag <= '0;
    end else begin
      out_vld <= in_vld;
      out_bin <= in_bin;
      out_mag <= mag_sum;
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame peak-bin search and total energy over the FFT output stream, one result per frame.
// Latency: last bin accepted at T -> out_push_F at T+3 when out_stall is low.
// Backpressure: single result buffer; only the final bin of the next frame is stalled while it is full.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter bit SKIP_DC = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_push,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     in_stall,
  output logic                     out_push_F,
  output logic [BIN_W-1:0]         out_peak_bin_F,
  output logic [MAG_W-1:0]         out_peak_mag_F,
  output logic [ENERGY_W-1:0]      out_energy_F,
  input  logic                     out_stall
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_POINTS - 1);

  logic                accept;
  logic [BIN_W-1:0]    bin_cnt;
  logic                s1_vld;
  logic [BIN_W-1:0]    s1_bin;
  logic [MAG_W-1:0]    s1_mag;
  logic [ENERGY_W-1:0] energy_acc;
  logic [MAG_W-1:0]    peak_mag;
  logic [BIN_W-1:0]    peak_bin;
  logic [ENERGY_W-1:0] nxt_energy;
  logic [MAG_W-1:0]    nxt_peak_mag;
  logic [BIN_W-1:0]    nxt_peak_bin;
  logic                load_result;
  logic                drain_result;
  logic                result_full;
  result_t             result_buf;

  // Holding back only the last bin of the next frame lets the earlier bins keep streaming
  // while a finished result waits for the downstream consumer.
  assign in_stall     = result_full && ((s1_vld && (s1_bin == LAST_BIN)) || (bin_cnt == LAST_BIN));
  assign accept       = in_push && !in_stall;
  assign load_result  = s1_vld && (s1_bin == LAST_BIN);
  assign drain_result = result_full && !out_stall;

  // Bin index of the next accepted sample; wraps at the frame boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_cnt <= '0;
    end else if (accept) begin
      bin_cnt <= (bin_cnt == LAST_BIN) ? '0 : bin_cnt + 1'b1;
    end
  end

  fft_mag_sq u_mag_sq (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (accept),
    .in_bin  (bin_cnt),
    .in_real (in_real),
    .in_imag (in_imag),
    .out_vld (s1_vld),
    .out_bin (s1_bin),
    .out_mag (s1_mag)
  );

  // Accumulator update including the current bin; bin 0 restarts the frame so frames never blend.
  always_comb begin
    nxt_energy   = energy_acc;
    nxt_peak_mag = peak_mag;
    nxt_peak_bin = peak_bin;
    if (s1_vld) begin
      if (s1_bin == '0) begin
        nxt_energy   = ENERGY_W'(s1_mag);
        nxt_peak_bin = '0;
        nxt_peak_mag = SKIP_DC ? '0 : s1_mag;
      end else begin
        nxt_energy = energy_acc + ENERGY_W'(s1_mag);
        // Strict compare keeps the lowest index on ties; with DC skipped, bin 1 always takes over.
        if ((SKIP_DC && (s1_bin == BIN_W'(1))) || (s1_mag > peak_mag)) begin
          nxt_peak_mag = s1_mag;
          nxt_peak_bin = s1_bin;
        end
      end
    end
  end

  // Stage-2 accumulator registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      energy_acc <= '0;
      peak_mag   <= '0;
      peak_bin   <= '0;
    end else begin
      energy_acc <= nxt_energy;
      peak_mag   <= nxt_peak_mag;
      peak_bin   <= nxt_peak_bin;
    end
  end

  // Single-entry result buffer; a load takes priority, though the stall rule keeps load and drain apart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_full <= 1'b0;
      result_buf  <= '0;
    end else if (load_result) begin
      result_full <= 1'b1;
      result_buf  <= '{peak_bin: nxt_peak_bin, peak_mag: nxt_peak_mag, energy: nxt_energy};
    end else if (drain_result) begin
      result_full <= 1'b0;
    end
  end

  // One-cycle result strobe; data fields hold their last value between pushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_push_F     <= 1'b0;
      out_peak_bin_F <= '0;
      out_peak_mag_F <= '0;
      out_energy_F   <= '0;
    end else begin
      out_push_F <= drain_result;
      if (drain_result) begin
        out_peak_bin_F <= result_buf.peak_bin;
        out_peak_mag_F <= result_buf.peak_mag;
        out_energy_F   <= result_buf.energy;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench: two detector instances (DC searched / DC skipped) fed the same stream.
// Latency: checked against the 3-cycle minimum when out_stall stays low.
// Backpressure: exercised by holding and randomising out_stall.
module tb_fft_peak_detect;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic in_push, out_stall;
  logic signed [DATA_W-1:0] in_real, in_imag;
  logic in_stall0, in_stall1, push0, push1;
  logic [BIN_W-1:0] pbin0, pbin1;
  logic [MAG_W-1:0] pmag0, pmag1;
  logic [ENERGY_W-1:0] en0, en1;

  always #5 clk = ~clk;

  fft_peak_detect #(.SKIP_DC(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_push(in_push), .in_real(in_real), .in_imag(in_imag),
    .in_stall(in_stall0), .out_push_F(push0), .out_peak_bin_F(pbin0),
    .out_peak_mag_F(pmag0), .out_energy_F(en0), .out_stall(out_stall));

  fft_peak_detect #(.SKIP_DC(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_push(in_push), .in_real(in_real), .in_imag(in_imag),
    .in_stall(in_stall1), .out_push_F(push1), .out_peak_bin_F(pbin1),
    .out_peak_mag_F(pmag1), .out_energy_F(en1), .out_stall(out_stall));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     bin;
    longint mag;
    longint energy;
    int     last_cyc;
    bit     chk_lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t me0, me1;
  logic signed [DATA_W-1:0] fr_re[N_POINTS];
  logic signed [DATA_W-1:0] fr_im[N_POINTS];
  int mcnt = 0;
  bit lat_chk = 1'b0;
  int stall_idx = -1;
  int first_acc = 0;
  int last_acc = 0;
  int npush0 = 0;
  int npush1 = 0;
  logic [63:0] cap0_bin, cap0_mag, cap0_en, cap1_bin, cap1_mag, cap1_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: magnitudes, energy and lowest-index argmax straight from the frame contents.
  function automatic exp_t frame_ref(input bit skip, input int last_c);
    exp_t   e;
    longint m;
    longint best;
    best = -1;
    e.bin = 0;
    e.mag = 0;
    e.energy = 0;
    for (int i = 0; i < N_POINTS; i++) begin
      m = longint'(fr_re[i]) * longint'(fr_re[i]) + longint'(fr_im[i]) * longint'(fr_im[i]);
      e.energy += m;
      if ((!skip || i != 0) && m > best) begin
        best  = m;
        e.bin = i;
        e.mag = m;
      end
    end
    e.last_cyc = last_c;
    e.chk_lat  = lat_chk;
    return e;
  endfunction

  task automatic model_accept(input logic signed [DATA_W-1:0] re, input logic signed [DATA_W-1:0] im,
                              input int c);
    fr_re[mcnt] = re;
    fr_im[mcnt] = im;
    mcnt++;
    if (mcnt == N_POINTS) begin
      q0.push_back(frame_ref(1'b0, c));
      q1.push_back(frame_ref(1'b1, c));
      mcnt = 0;
    end
  endtask

  // Offer one bin, hold it while stalled, and log it in the model once it is taken.
  task automatic send_bin(input logic signed [DATA_W-1:0] re, input logic signed [DATA_W-1:0] im);
    int w;
    w = 0;
    @(negedge clk);
    in_push = 1'b1;
    in_real = re;
    in_imag = im;
    #1;
    while (in_stall0 && w < 200) begin
      if (stall_idx < 0) stall_idx = mcnt;
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_bin_timeout: in_stall still high after %0d cycles, required low", w);
    end else begin
      if (mcnt == 0) first_acc = cyc;
      last_acc = cyc;
      model_accept(re, im, cyc);
    end
    @(posedge clk);
    #1;
    in_push = 1'b0;
  endtask

  task automatic wait_push(input string nm, input int target);
    int n;
    n = 0;
    while ((npush0 < target || npush1 < target) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, (npush0 >= target && npush1 >= target), 1);
  endtask

  // Output monitor: every push is matched in order against the reference queue.
  always @(negedge clk) begin
    if (push0) begin
      npush0++;
      cap0_bin = 64'(pbin0); cap0_mag = 64'(pmag0); cap0_en = 64'(en0);
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected_push: got a push, required none pending");
      end else begin
        me0 = q0.pop_front();
        chk("dut0_peak_bin", cap0_bin, me0.bin);
        chk("dut0_peak_mag", cap0_mag, me0.mag);
        chk("dut0_energy", cap0_en, me0.energy);
        if (me0.chk_lat) chk("dut0_latency", cyc - me0.last_cyc, 3);
      end
    end
    if (push1) begin
      npush1++;
      cap1_bin = 64'(pbin1); cap1_mag = 64'(pmag1); cap1_en = 64'(en1);
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_push: got a push, required none pending");
      end else begin
        me1 = q1.pop_front();
        chk("dut1_peak_bin", cap1_bin, me1.bin);
        chk("dut1_peak_mag", cap1_mag, me1.mag);
        chk("dut1_energy", cap1_en, me1.energy);
        if (me1.chk_lat) chk("dut1_latency", cyc - me1.last_cyc, 3);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string name;
    int ia; logic signed [15:0] ra; logic signed [15:0] ma;
    int ib; logic signed [15:0] rb; logic signed [15:0] mb;
    logic signed [15:0] rbg; logic signed [15:0] mbg;
    int bin0; longint mag0; longint e0;
    int bin1; longint mag1; longint e1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{"single", 5, 300, -400, 5, 300, -400, 1, 1,
                5, 64'd250000, 64'd250030, 5, 64'd250000, 64'd250030};
    vecs[1] = '{"tie", 3, 1000, 0, 9, 1000, 0, 0, 0,
                3, 64'd1000000, 64'd2000000, 3, 64'd1000000, 64'd2000000};
    vecs[2] = '{"extreme", 0, -32768, -32768, 0, -32768, -32768, -32768, -32768,
                0, 64'd2147483648, 64'd34359738368, 1, 64'd2147483648, 64'd34359738368};
    vecs[3] = '{"dc", 0, 5000, 0, 7, 10, 0, 0, 0,
                0, 64'd25000000, 64'd25000100, 7, 64'd100, 64'd25000100};

    reset = 1'b0; in_push = 1'b0; out_stall = 1'b0; in_real = '0; in_imag = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_stall", in_stall0, 0);
    chk("rst_push", push0, 0);
    chk("rst_peak_bin", pbin0, 0);
    chk("rst_peak_mag", pmag0, 0);
    chk("rst_energy", en0, 0);
    reset = 1'b1;

    // Directed frames from the table, out_stall low so latency is checked too.
    lat_chk = 1'b1;
    for (int v = 0; v < 4; v++) begin
      int base;
      base = npush0;
      for (int i = 0; i < N_POINTS; i++) begin
        if (i == vecs[v].ia)      send_bin(vecs[v].ra, vecs[v].ma);
        else if (i == vecs[v].ib) send_bin(vecs[v].rb, vecs[v].mb);
        else                      send_bin(vecs[v].rbg, vecs[v].mbg);
      end
      wait_push({vecs[v].name, "_push"}, base + 1);
      chk({vecs[v].name, "_bin0"}, cap0_bin, vecs[v].bin0);
      chk({vecs[v].name, "_mag0"}, cap0_mag, vecs[v].mag0);
      chk({vecs[v].name, "_en0"}, cap0_en, vecs[v].e0);
      chk({vecs[v].name, "_bin1"}, cap1_bin, vecs[v].bin1);
      chk({vecs[v].name, "_mag1"}, cap1_mag, vecs[v].mag1);
      chk({vecs[v].name, "_en1"}, cap1_en, vecs[v].e1);
    end

    // Back-to-back frames: one bin per cycle, no stall.
    begin
      int base;
      base = npush0;
      stall_idx = -1;
      for (int i = 0; i < 2 * N_POINTS; i++)
        send_bin(DATA_W'($urandom_range(0, 2000)), DATA_W'($urandom_range(0, 2000)));
      chk("b2b_no_stall", stall_idx, -1);
      chk("b2b_cycles", last_acc - first_acc, N_POINTS - 1);
      wait_push("b2b_push", base + 2);
    end

    // Backpressure: frame 1 result held, frame 2 stalls only on its last bin.
    begin
      int base;
      lat_chk = 1'b0;
      base = npush0;
      out_stall = 1'b1;
      stall_idx = -1;
      for (int i = 0; i < N_POINTS; i++) send_bin(DATA_W'(i * 37), DATA_W'(-i));
      chk("bp_frame1_no_stall", stall_idx, -1);
      fork
        begin
          for (int i = 0; i < N_POINTS; i++) send_bin(DATA_W'(500 - i * 20), 16'sd3);
        end
        begin
          repeat (20) @(negedge clk);
          chk("bp_held", npush0 - base, 0);
          out_stall = 1'b0;
        end
      join
      chk("bp_stall_idx", stall_idx, N_POINTS - 1);
      wait_push("bp_push", base + 2);
    end

    // Randomised frames with idle gaps and toggling downstream stall.
    for (int f = 0; f < 12; f++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < N_POINTS; i++) begin
        out_stall = ($urandom_range(0, 3) == 0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        if (mode == 0)      send_bin(DATA_W'($urandom), DATA_W'($urandom));
        else if (mode == 1) send_bin(DATA_W'($urandom_range(0, 3)), DATA_W'($urandom_range(0, 3)));
        else                send_bin(-16'sd7, 16'sd7);
      end
    end
    out_stall = 1'b0;
    begin
      int n;
      n = 0;
      while ((q0.size() + q1.size()) != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rand_drained", q0.size() + q1.size(), 0);

    // Reset mid-frame: partial frame discarded, exactly one result from the new frame.
    begin
      int base0, base1;
      lat_chk = 1'b1;
      for (int i = 0; i < 8; i++) send_bin(16'sd30000, 16'sd30000);
      @(negedge clk);
      reset = 1'b0;
      mcnt = 0;
      repeat (2) @(negedge clk);
      chk("mid_rst_mag", pmag0, 0);
      chk("mid_rst_energy", en0, 0);
      chk("mid_rst_in_stall", in_stall0, 0);
      reset = 1'b1;
      base0 = npush0;
      base1 = npush1;
      for (int i = 0; i < N_POINTS; i++) send_bin(DATA_W'(i), DATA_W'(2 * i));
      repeat (30) @(negedge clk);
      chk("mid_rst_one_push0", npush0 - base0, 1);
      chk("mid_rst_one_push1", npush1 - base1, 1);
      chk("mid_rst_bin0", cap0_bin, N_POINTS - 1);
    end

    chk("final_drained", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Downstream consumer of the FFT output stream.
- Takes the 16 bins of each transformed frame, in the order the FFT emits them.
- Per bin: computes magnitude-squared (re² + im²).
- Per frame: tracks the peak bin and accumulates total spectral energy, then emits one result record.
- Connects directly to the FFT output push/stall interface and presents a push/stall interface to the next consumer.

Parameters:
- N_POINTS, 16, bins per frame; power of two.
- DATA_W, 16, signed width of each real/imag input.
- MAG_W, 32, magnitude-squared width (2*DATA_W).
- BIN_W, 4, bin index width (log2 N_POINTS).
- SKIP_DC, 0, when 1 bin 0 is excluded from peak search but still included in energy.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_push  in  1  input bin valid (from FFT out_push_F)
- in_real  in  DATA_W  signed real part
- in_imag  in  DATA_W  signed imag part
- in_stall  out  1  backpressure to FFT (drives its out_stall)
- out_push_F  out  1  one-cycle result strobe
- out_peak_bin_F  out  BIN_W  index of largest-magnitude bin
- out_peak_mag_F  out  MAG_W  magnitude-squared of the peak bin
- out_energy_F  out  MAG_W+BIN_W  sum of all bin magnitudes in the frame
- out_stall  in  1  downstream backpressure

Behaviour:
- Reset (reset=0, async) clears all registers: outputs 0, bin counter 0, accumulators 0, result buffer empty, in_stall=0.
- Accept condition: in_push && !in_stall. If in_push arrives while in_stall=1, the data is ignored and the counter does not advance; the FFT holds off on stall.
- Stage 1 (registered): mag = in_real² + in_imag², computed as signed squares summed unsigned. Worst case (-32768)² * 2 = 2^31, which fits MAG_W with no saturation. The valid bit and bin index travel with the data.
- Bin counter: BIN_W-bit, increments on each accept, wraps from N_POINTS-1 to 0. The bin index is the count at accept time.
- Stage 2 (registered), processing stage-1 outputs:
  - energy_acc += mag.
  - Peak updates when the bin is eligible and mag > peak_mag (strictly greater), so ties keep the lowest index.
  - Bin 0 seeds the accumulators (overwrite, not add) so frames do not blend. If SKIP_DC=1, bin 0 seeds peak_mag=0, peak_bin=0, and bin 1 always replaces it.
- Frame completion: when stage 2 processes bin N_POINTS-1, the final peak bin, peak magnitude and energy (including that bin) load into a single-entry result buffer, and result_full is set.
- Output handshake: in the cycle after result_full is set, if out_stall=0, assert out_push_F for exactly one cycle with the result fields valid, then clear result_full. If out_stall=1, hold the buffer and keep out_push_F=0; push on the first cycle out_stall is low.
- The out_*_F data fields keep their last value between pushes.
- Latency: last bin accepted at cycle T, stage 1 at T+1, result_full at T+2, out_push_F at T+3 (minimum).
- in_stall = result_full && (stage-1 or stage-2 holds bin N_POINTS-1 of the next frame, or the counter is at N_POINTS-1). This blocks only the final bin of the next frame, so earlier bins keep streaming.
- Simultaneous events: result drain and a new result load in the same cycle cannot occur, because the stall rule guarantees it.
- Back-to-back frames with out_stall=0 sustain one bin per cycle with no bubbles.
- Reset mid-frame: the partial frame is discarded, the pending result is dropped, and the next accepted bin is bin 0.

Decomposition:
- Shared package fft_pkg:
  - constants N_POINTS, DATA_W, BIN_W, MAG_W, ENERGY_W;
  - a result record typedef {peak_bin, peak_mag, energy}.
- One natural sub-module: fft_mag_sq, the registered stage-1 squarer/adder with valid and bin pass-through. It is reusable for a future power-spectrum output.
- Comparator, accumulator and result buffer stay in the top of the block.

Test Plan:
- Single frame with bin 5 = (300, -400) and all other bins (1, 1), out_stall=0 -> out_push_F once, exactly 3 cycles after the last bin. peak_bin=5, peak_mag=250000, energy=250000+15*2=250030.
- Tie: bins 3 and 9 both (1000, 0), others 0 -> peak_bin=3, peak_mag=1000000.
- Extreme values: all bins (-32768, -32768) -> peak_bin=0, peak_mag=2147483648, energy=2^35, no overflow.
- Backpressure: hold out_stall=1 for 20 cycles after frame 1 while frame 2 streams -> frame 1 result is held. in_stall rises only when frame 2's last bin is offered. On out_stall release: frame 1 pushes, then frame 2; no data lost and the counter stays consistent.
- SKIP_DC=1, bin 0 = (5000, 0), bin 7 = (10, 0), others 0 -> peak_bin=7, peak_mag=100, energy=25000100.
- Assert reset mid-frame after 8 bins, release, send a full frame -> exactly one out_push_F, with results from the new frame only.
